// File: rtl/logic_unit_seq_pkg.sv
// Shared types for the sequential bitwise logic unit: op encodings and FSM states.
package logic_unit_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_XNOR  = 3'b100,
        OP_NAND  = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_seq_lane.sv
// Combinational LANE-bit slice evaluator for one of the eight bitwise ops.
module logic_lane
    import logic_unit_pkg::*;
#(
    parameter int LANE = 8
) (
    input  logic [LANE-1:0] a_s,
    input  logic [LANE-1:0] b_s,
    input  op_t             op,
    output logic [LANE-1:0] y_s
);

    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:   y_s = a_s & b_s;
            OP_OR:    y_s = a_s | b_s;
            OP_XOR:   y_s = a_s ^ b_s;
            OP_NOR:   y_s = ~(a_s | b_s);
            OP_XNOR:  y_s = ~(a_s ^ b_s);
            OP_NAND:  y_s = ~(a_s & b_s);
            OP_ANDN:  y_s = a_s & ~b_s;
            OP_PASSA: y_s = a_s;
            default:  y_s = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: WIDTH-bit op evaluated LANE bits per cycle.
// Optional macro LOGIC_UNIT_SEQ_B2B_EN allows accepting a new op in DONE as the result is consumed.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OP_WIDTH-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                parity
);

    localparam int NCHUNK = (LANE > 0) ? WIDTH / LANE : 1;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (LANE < 1 || (WIDTH % LANE) != 0) begin : g_bad_lane
            $error("logic_unit_seq: LANE must evenly divide WIDTH");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               parity_q, parity_d;
    logic               par_acc_q, par_acc_d;
    logic               nz_acc_q, nz_acc_d;

    logic [LANE-1:0]    a_s, b_s, y_s;
    logic               in_ready_st;
    logic               accept;
    logic               last_chunk;

    // A transfer happens on an edge where valid and ready are both high; the
    // producer holds its payload until then and ready never waits on valid.
    always_comb begin
        in_ready_st = (state_q == IDLE);
`ifdef LOGIC_UNIT_SEQ_B2B_EN
        in_ready_st = in_ready_st | ((state_q == DONE) & out_ready);
`endif
    end

    assign in_ready   = rst_n & in_ready_st;
    assign accept     = in_valid & in_ready;
    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

    assign a_s = a_q[cnt_q*LANE +: LANE];
    assign b_s = b_q[cnt_q*LANE +: LANE];

    logic_lane #(.LANE(LANE)) u_lane (
        .a_s (a_s),
        .b_s (b_s),
        .op  (op_q),
        .y_s (y_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        parity_d  = parity_q;
        par_acc_d = par_acc_q;
        nz_acc_d  = nz_acc_q;

        case (state_q)
            IDLE: ;
            BUSY: begin
                result_d[cnt_q*LANE +: LANE] = y_s;
                par_acc_d = par_acc_q ^ (^y_s);
                nz_acc_d  = nz_acc_q | (|y_s);
                if (last_chunk) begin
                    cnt_d    = '0;
                    zero_d   = ~nz_acc_d;
                    parity_d = par_acc_d;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // accept is only possible in IDLE, or in DONE when back-to-back is enabled
        if (accept) begin
            a_d       = a;
            b_d       = b;
            op_d      = op_t'(op);
            cnt_d     = '0;
            par_acc_d = 1'b0;
            nz_acc_d  = 1'b0;
            state_d   = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            result_q  <= '0;
            zero_q    <= 1'b0;
            parity_q  <= 1'b0;
            par_acc_q <= 1'b0;
            nz_acc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            parity_q  <= parity_d;
            par_acc_q <= par_acc_d;
            nz_acc_q  <= nz_acc_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
- Parametrised, multi-cycle bitwise logic unit for the ALU datapath; generalises the fixed 32-bit single-op gate array.
- Computes one of eight bitwise ops on WIDTH-bit operands, LANE bits per cycle, over WIDTH/LANE cycles.
- Produces result plus zero and parity flags.
- valid/ready handshake on both input and output sides, so it can sit behind the operand latch and ahead of the writeback mux.

Parameters:
- WIDTH, 32, operand/result width in bits.
- LANE, 8, bits processed per cycle. Must divide WIDTH; violation is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- parity  out  1  XOR-reduction of result

Behaviour:
- Interface: one clock clk; asynchronous active-low reset rst_n.
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 NAND, 110 ANDN (a & ~b), 111 PASSA (a).
- Reset (async assert, sync release):
  - state=IDLE, chunk counter=0.
  - result=0, zero=0, parity=0, out_valid=0.
  - in_ready=0 while rst_n low.
- FSM, IDLE -> BUSY -> DONE:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b, op; clear counter, parity accumulator, nonzero accumulator; go BUSY.
  - BUSY: in_ready=0. Each cycle, compute slice [cnt*LANE +: LANE] and write it into result.
    - Accumulators: parity ^= ^slice; nonzero |= |slice. Increment cnt.
    - On the edge processing the last chunk (cnt == WIDTH/LANE-1), go DONE.
  - DONE: out_valid=1; zero = ~nonzero; parity = accumulator. On out_ready, go IDLE.
- Latency: out_valid rises exactly WIDTH/LANE cycles after the accepting edge (4 for defaults). LANE=WIDTH gives 1.
- Outputs during BUSY:
  - result, zero and parity hold stable while out_valid & ~out_ready.
  - result is partially updated during BUSY and is not to be consumed before out_valid.
- Latching: a, b, op are sampled only at accept; later input changes are ignored.
- Default mode, DONE with out_ready=1: in_ready=0 that cycle; the next accept is no earlier than the following cycle (IDLE).
- Reset mid-BUSY or mid-DONE: transaction discarded; all outputs return to reset values; no partial result is delivered.
- Counter width: $clog2(WIDTH/LANE), minimum 1 bit. Wrap to 0 occurs only on the DONE transition.

Optional Feature:
- Macro: LOGIC_UNIT_SEQ_B2B_EN.
- Defined: in_ready = (state==IDLE) | (state==DONE & out_ready). An accept in DONE latches new operands and goes directly to BUSY on the same edge the result is consumed. Sustained throughput: one op per WIDTH/LANE+1 cycles.
- Undefined: in_ready only in IDLE; throughput one op per WIDTH/LANE+2 cycles.

Decomposition:
- Package logic_unit_pkg:
  - op_t enum (3-bit, encodings above).
  - state_t enum (IDLE, BUSY, DONE).
  - OP_WIDTH=3 constant.
- Sub-module logic_lane: combinational LANE-bit slice evaluator (a_s, b_s, op -> y_s), instanced once and fed by the counter-selected slice.

Test Plan:
1. WIDTH=32, LANE=8, XOR, a=0xFFFF0000, b=0x0F0F0F0F -> result 0xF0F00F0F, zero=0, parity=0, out_valid exactly 4 cycles after accept.
2. XOR, a=b=0xDEADBEEF -> result 0x00000000, zero=1, parity=0.
3. AND, a=0x12345678, b=0xFFFF0000, out_ready held 0 for 5 cycles -> result 0x12340000, parity=1. Outputs stable, in_ready=0 throughout; returns to IDLE on the cycle after out_ready=1.
4. NOR, a=0, b=0 -> 0xFFFFFFFF, parity=0, zero=0. Sweep all 8 ops on random operands against a reference model; also run LANE=32 (latency 1) and LANE=4 (latency 8).
5. rst_n pulsed low after 2 BUSY cycles -> out_valid=0, result=0 immediately. After release, in_ready=1 and the next XOR transaction is correct.
6. With LOGIC_UNIT_SEQ_B2B_EN: in_valid held high with out_ready=1 -> second op accepted on the same edge the first result handshakes; out_valid pulses every 5 cycles. Without the macro: every 6 cycles.
